mdu_param: RTL and testbench
============================

# mdu_param

Parametrised multiply/divide unit holding the HI/LO register pair for the pipelined MIPS core. It sits in the E stage, where the decoder already supplies `md_s`, `md_c` and `m_md`. It executes signed and unsigned multiply and divide, `mthi`/`mtlo`, and the new multiply-accumulate ops (`madd`, `maddu`, `msub`, `msubu`). Multiply and divide latencies are configurable. A `busy` flag lets the hazard unit stall md-dependent instructions.

## Interface
- `WIDTH`, 32: operand and HI/LO width in bits.
- `MULT_LAT`, 5: busy cycles for multiply and multiply-accumulate ops. Must be ≥1.
- `DIV_LAT`, 10: busy cycles for divide ops. Must be ≥1.

- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `md_s`  in  1: start strobe. Sampled on the rising edge.
- `md_c`  in  4: op code. 0 multu, 1 mult, 2 divu, 3 div, 4 mthi, 5 mtlo, 6 madd, 7 maddu, 8 msub, 9 msubu. Codes 10–15 are no-ops.
- `a`  in  WIDTH: operand rs.
- `b`  in  WIDTH: operand rt.
- `m_md`  in  1: read select. 0 selects HI, 1 selects LO.
- `busy`  out  1: high while a timed op is in flight.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.
- `rd_data`  out  WIDTH: combinational read, `m_md ? lo : hi`.

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, internal counter=0, pending result discarded.
- Accept condition: `md_s`=1, `busy`=0 and `reset`=0 at an edge.
  - If `md_s`=1 while `busy`=1, the start is ignored entirely: no state change and no queueing. The upstream stall must prevent this.
- On accept, `a`, `b`, `md_c` and the current HI:LO are captured. Later changes to the inputs have no effect on the result.
- mthi / mtlo:
  - Write `a` into HI / LO at the accepting edge.
  - `busy` stays 0.
  - The other register is unchanged.
- multu / mult:
  - HI:LO = 2·WIDTH-bit product of `a`·`b`, treated unsigned / two's-complement signed respectively.
- madd / maddu:
  - HI:LO = HI:LO + product, computed modulo 2^(2·WIDTH).
  - madd uses the signed product; maddu uses the unsigned product.
- msub / msubu:
  - HI:LO = HI:LO − product, computed modulo 2^(2·WIDTH).
  - Signedness as for madd / maddu.
  - The HI:LO used is the value captured at accept.
- divu / div:
  - LO = quotient, truncated toward zero.
  - HI = remainder; its sign follows the dividend for div.
  - div with `a`=most-negative and `b`=−1: LO = most-negative, HI = 0.
  - `b`=0: the op still runs its full latency, but HI and LO stay unchanged at completion.
- Codes 10–15 with `md_s`=1: no state change, `busy` stays 0.
- State machine:
  - IDLE → RUN on accept of a timed op. The counter loads MULT_LAT or DIV_LAT.
  - In RUN, the counter decrements every edge.
  - At the edge where the counter goes 1→0: HI/LO commit, `busy` drops, state returns to IDLE.
- Counter width is $clog2(max(MULT_LAT, DIV_LAT)+1).
- Reset mid-operation: aborts the op. No commit; outputs return to reset values at that edge.

## Timing
- Timed op accepted at edge E0:
  - `busy`=1 for exactly LAT cycles, from after E0 to after E(LAT).
  - HI/LO take the new value at edge E(LAT), the same edge `busy` falls.
  - A start at E(LAT) itself is not accepted, because `busy` is still 1 when sampled. The earliest next accept is E(LAT+1).
- mthi/mtlo: zero added latency; the new value is visible after the accepting edge.
- `rd_data`: combinational from the HI/LO registers. No bypass of the in-flight result.
- During RUN, `hi`/`lo` hold their pre-op values.

## Test plan
Default parameters are assumed unless stated.
- **Multiply:**
  - mult, `a`=0xFFFFFFFE, `b`=3 → `busy` high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - multu, same operands → HI=0x00000002, LO=0xFFFFFFFA.
- **Divide:**
  - div, `a`=0xFFFFFFF9 (−7), `b`=2 → `busy` for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu, `a`=7, `b`=2 → LO=3, HI=1.
- **Divide edge cases:**
  - With HI=0x11, LO=0x22: div by `b`=0 → after 10 cycles HI=0x11, LO=0x22.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **Accumulate wrap:**
  - mthi 0, mtlo 0xFFFFFFFF, then maddu 1·1 → HI=1, LO=0.
  - From HI:LO=0, msubu 1·1 → HI=LO=0xFFFFFFFF.
  - From HI:LO=0, msub with `a`=0xFFFFFFFF, `b`=1 → HI=0, LO=1.
- **Ignored starts and reset abort:**
  - mult 3·4; at cycle 2 of `busy` assert mtlo 0x55 → ignored, final LO=12.
  - Repeat the mult and assert `reset` in cycle 3 → `busy`=0, HI=LO=0 next cycle, no later commit.
- **Read path and parameters:**
  - mthi 0x1234 → `rd_data`=0x1234 with `m_md`=0, and equals LO with `m_md`=1.
  - Rerun the mult test with MULT_LAT=1 → `busy` high exactly 1 cycle.
  - Rerun with WIDTH=16: mult 0xFFFE·3 → HI=0xFFFF, LO=0xFFFA.

Source files
------------

// File: rtl/mdu_param_if.sv
// rtl/mdu_param_if.sv - E-stage multiply/divide unit request and HI/LO read bundle
interface mdu_param_if #(
  parameter int WIDTH = 32
);
  logic             md_s;
  logic [3:0]       md_c;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             m_md;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output md_s, md_c, a, b, m_md,
    input  busy, hi, lo, rd_data
  );

  modport slave (
    input  md_s, md_c, a, b, m_md,
    output busy, hi, lo, rd_data
  );
endinterface

// File: rtl/mdu_param.sv
// rtl/mdu_param.sv - parametrised multiply/divide/accumulate unit with HI/LO pair
module mdu_param #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic        clk,
  input logic        reset,
  mdu_param_if.slave md
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam int W2      = 2 * WIDTH;

  localparam logic [3:0] OP_MULTU = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e           state;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [W2-1:0]    acc_q;

  // Result is formed from the operands captured at accept, so inputs may move freely during RUN.
  logic             is_signed_mul;
  logic [W2-1:0]    a_ext;
  logic [W2-1:0]    b_ext;
  logic [W2-1:0]    prod;
  logic             sdiv;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_den;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [W2-1:0]    result;
  logic             is_div;
  logic             div_zero;

  always_comb begin
    is_signed_mul = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    a_ext = is_signed_mul ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext = is_signed_mul ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = a_ext * b_ext;

    // Divide on magnitudes, then restore signs; most-negative / -1 wraps back to most-negative.
    sdiv  = (op_q == OP_DIV);
    a_neg = sdiv & a_q[WIDTH-1];
    b_neg = sdiv & b_q[WIDTH-1];
    a_mag = a_neg ? (~a_q + WIDTH'(1)) : a_q;
    b_mag = b_neg ? (~b_q + WIDTH'(1)) : b_q;
    b_den = (b_mag == '0) ? WIDTH'(1) : b_mag;
    q_mag = a_mag / b_den;
    r_mag = a_mag % b_den;
    quot  = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
    rem   = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;

    is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    div_zero = is_div && (b_q == '0);

    case (op_q)
      OP_MADD, OP_MADDU: result = acc_q + prod;
      OP_MSUB, OP_MSUBU: result = acc_q - prod;
      OP_DIV, OP_DIVU:   result = {rem, quot};
      default:           result = prod;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md.md_s) begin
            case (md.md_c)
              OP_MTHI: hi_q <= md.a;
              OP_MTLO: lo_q <= md.a;
              OP_MULTU, OP_MULT, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
              OP_DIVU, OP_DIV: begin
                op_q   <= md.md_c;
                a_q    <= md.a;
                b_q    <= md.b;
                acc_q  <= {hi_q, lo_q};
                cnt    <= ((md.md_c == OP_DIV) || (md.md_c == OP_DIVU)) ?
                          CW'(DIV_LAT) : CW'(MULT_LAT);
                busy_q <= 1'b1;
                state  <= ST_RUN;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (!div_zero) begin
              hi_q <= result[W2-1:WIDTH];
              lo_q <= result[WIDTH-1:0];
            end
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign md.busy    = busy_q;
  assign md.hi      = hi_q;
  assign md.lo      = lo_q;
  assign md.rd_data = md.m_md ? lo_q : hi_q;

endmodule

// File: tb/tb_mdu_param.sv
// tb/tb_mdu_param.sv - scoreboard bench for mdu_param across three parameter sets
module tb_mdu_param;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mdu_param_if #(.WIDTH(32)) m ();
  mdu_param_if #(.WIDTH(32)) m1 ();
  mdu_param_if #(.WIDTH(16)) m16 ();

  mdu_param #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (.clk(clk), .reset(reset), .md(m.slave));
  mdu_param #(.WIDTH(32), .MULT_LAT(1), .DIV_LAT(10)) dut_l1 (.clk(clk), .reset(reset), .md(m1.slave));
  mdu_param #(.WIDTH(16), .MULT_LAT(5), .DIV_LAT(10)) dut_w16 (.clk(clk), .reset(reset), .md(m16.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_cmp(input string tag, input logic [63:0] got);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, got, e);
    end
  endtask

  task automatic wait_idle(input string tag, input int elat);
    int n = 0;
    while (m.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(n), 64'(elat));
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat);
    exp_q.push_back({ehi, elo});
    @(negedge clk);
    m.md_s = 1'b1; m.md_c = op; m.a = ia; m.b = ib;
    @(negedge clk);
    m.md_s = 1'b0; m.a = $urandom; m.b = $urandom;
    wait_idle(tag, elat);
    pop_cmp({tag, "_hilo"}, {m.hi, m.lo});
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    longint sa, sb;
    logic [63:0] p;
    int n;

    m.md_s = 0; m.md_c = 0; m.a = 0; m.b = 0; m.m_md = 0;
    m1.md_s = 0; m1.md_c = 0; m1.a = 0; m1.b = 0; m1.m_md = 0;
    m16.md_s = 0; m16.md_c = 0; m16.a = 0; m16.b = 0; m16.m_md = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_hilo", {m.hi, m.lo}, 64'd0);
    chk("rst_busy", 64'(m.busy), 64'd0);
    chk("rst_rd", 64'(m.rd_data), 64'd0);

    run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    run_op("multu", 4'd0, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5);
    run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op("divu", 4'd2, 32'd7, 32'd2, 32'd1, 32'd3, 10);
    run_op("mthi11", 4'd4, 32'h11, 32'd0, 32'h11, 32'd3, 0);
    run_op("mtlo22", 4'd5, 32'h22, 32'd0, 32'h11, 32'h22, 0);
    run_op("div0", 4'd3, 32'd5, 32'd0, 32'h11, 32'h22, 10);
    run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);
    run_op("mthi0", 4'd4, 32'd0, 32'd0, 32'd0, 32'h80000000, 0);
    run_op("mtloff", 4'd5, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 0);
    run_op("maddu", 4'd7, 32'd1, 32'd1, 32'd1, 32'd0, 5);
    run_op("clrhi", 4'd4, 32'd0, 32'd0, 32'd0, 32'd0, 0);
    run_op("msubu", 4'd9, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
    run_op("clrhi2", 4'd4, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 0);
    run_op("clrlo2", 4'd5, 32'd0, 32'd0, 32'd0, 32'd0, 0);
    run_op("msub", 4'd8, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1, 5);
    run_op("madd", 4'd6, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFB, 5);
    run_op("nop12", 4'd12, 32'h5A5A, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFB, 0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      sa = $signed(ra); sb = $signed(rb);
      p = 64'(sa * sb);
      run_op("rmult", 4'd1, ra, rb, p[63:32], p[31:0], 5);
      rb = $urandom_range(1, 1000);
      run_op("rdivu", 4'd2, ra, rb, ra % rb, ra / rb, 10);
    end

    // Start during busy must be dropped; mult result must still land.
    exp_q.push_back({32'd0, 32'd12});
    @(negedge clk);
    m.md_s = 1; m.md_c = 4'd1; m.a = 32'd3; m.b = 32'd4;
    @(negedge clk);
    m.md_s = 0;
    @(negedge clk);
    m.md_s = 1; m.md_c = 4'd5; m.a = 32'h55;
    @(negedge clk);
    m.md_s = 0;
    wait_idle("ign", 3);
    pop_cmp("ign_hilo", {m.hi, m.lo});
    @(negedge clk);
    chk("ign_busy_after", 64'(m.busy), 64'd0);

    // Reset in busy cycle 3 aborts without a later commit.
    run_op("prehi", 4'd4, 32'h99, 32'd0, 32'h99, 32'd12, 0);
    @(negedge clk);
    m.md_s = 1; m.md_c = 4'd1; m.a = 32'd3; m.b = 32'd4;
    @(negedge clk);
    m.md_s = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(m.busy), 64'd0);
    exp_q.push_back(64'd0);
    repeat (8) @(negedge clk);
    pop_cmp("abort_hilo", {m.hi, m.lo});
    chk("abort_busy_late", 64'(m.busy), 64'd0);

    run_op("mthi1234", 4'd4, 32'h1234, 32'd0, 32'h1234, 32'd0, 0);
    m.m_md = 0; #1;
    chk("rd_hi", 64'(m.rd_data), 64'h1234);
    m.m_md = 1; #1;
    chk("rd_lo", 64'(m.rd_data), 64'd0);
    run_op("mtloabcd", 4'd5, 32'hABCD, 32'd0, 32'h1234, 32'hABCD, 0);
    chk("rd_lo2", 64'(m.rd_data), 64'hABCD);

    // MULT_LAT=1 instance
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
    @(negedge clk);
    m1.md_s = 1; m1.md_c = 4'd1; m1.a = 32'hFFFFFFFE; m1.b = 32'd3;
    @(negedge clk);
    m1.md_s = 0;
    n = 0;
    while (m1.busy && n < 50) begin n++; @(negedge clk); end
    chk("l1_lat", 64'(n), 64'd1);
    pop_cmp("l1_hilo", {m1.hi, m1.lo});

    // WIDTH=16 instance
    exp_q.push_back({32'hFFFF, 32'hFFFA});
    @(negedge clk);
    m16.md_s = 1; m16.md_c = 4'd1; m16.a = 16'hFFFE; m16.b = 16'd3;
    @(negedge clk);
    m16.md_s = 0;
    n = 0;
    while (m16.busy && n < 50) begin n++; @(negedge clk); end
    chk("w16_lat", 64'(n), 64'd5);
    pop_cmp("w16_hilo", {16'd0, m16.hi, 16'd0, m16.lo});

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
